// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC to instruction memory and buffers
// {pc, instruction} pairs in a small FIFO for decode; redirects flush the FIFO.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        misaligned
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] PC_INIT  = {RESET_PC[31:2], 2'b00};

    logic [31:0]   pc;
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [31:0]   q_pc  [DEPTH];
    logic [31:0]   q_ins [DEPTH];
    logic          pop, push;

    assign pc_address     = pc;
    assign if_valid       = (count != '0) && !redirect_valid;
    assign if_instruction = q_ins[head];
    assign if_pc          = q_pc[head];
    assign pop            = if_valid && id_ready;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push           = !redirect_valid && ((count < CNT_FULL) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= PC_INIT;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc    <= {redirect_pc[31:2], 2'b00};
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    pc   <= pc + 32'd4;
                    tail <= tail + PTR_ONE;
                end
                if (pop)
                    head <= head + PTR_ONE;
                if (push && !pop)
                    count <= count + CNT_ONE;
                else if (pop && !push)
                    count <= count - CNT_ONE;
            end
        end
    end

    // Entries reset to a NOP at RESET_PC so the head reads sensibly out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]  <= PC_INIT;
                q_ins[i] <= NOP;
            end
        end else if (push) begin
            q_pc[tail]  <= pc;
            q_ins[tail] <= instruction;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus
// directed literal checks for reset, stall, redirect, misalignment and PC wrap.
module tb_fetch_unit;
    localparam int          QDEPTH = 2;
    localparam logic [31:0] RPC    = 32'h0000_0000;

    logic        clk, rst_n;
    logic [31:0] pc_address, instruction, redirect_pc, if_instruction, if_pc;
    logic        redirect_valid, if_valid, id_ready, misaligned;
    logic [31:0] key;

    logic [31:0] pc2, ins2, ifi2, ifp2;
    logic        v2, mis2;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc_address(pc_address), .instruction(instruction),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_instruction(if_instruction), .if_pc(if_pc), .id_ready(id_ready),
        .misaligned(misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc_address(pc2), .instruction(ins2),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .if_valid(v2),
        .if_instruction(ifi2), .if_pc(ifp2), .id_ready(1'b1), .misaligned(mis2)
    );

    // Instruction memory: word i holds i, optionally scrambled by a per-cycle key.
    assign instruction = (pc_address >> 2) ^ key;
    assign ins2        = pc2 >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t        q[$];
    logic [31:0] mpc  = RPC;
    logic        mmis = 1'b0;
    logic        rst_seen = 1'b0;

    always @(negedge rst_n) rst_seen = 1'b1;

    always @(negedge clk) begin
        logic exp_v, popd, full;
        if (!rst_n || rst_seen) begin
            q.delete();
            mpc      = RPC;
            mmis     = 1'b0;
            rst_seen = 1'b0;
        end
        exp_v = (q.size() != 0) && !redirect_valid;
        chk("m_pc_address", pc_address, mpc);
        chk("m_misaligned", {31'b0, misaligned}, {31'b0, mmis});
        chk("m_if_valid", {31'b0, if_valid}, {31'b0, exp_v});
        if (exp_v) begin
            chk("m_if_pc", if_pc, q[0].pc);
            chk("m_if_instruction", if_instruction, q[0].ins);
        end
        if (!rst_n) begin
            chk("m_rst_if_instruction", if_instruction, 32'h0000_0013);
            chk("m_rst_if_pc", if_pc, RPC);
        end else if (redirect_valid) begin
            q.delete();
            mpc  = {redirect_pc[31:2], 2'b00};
            mmis = (redirect_pc[1:0] != 2'b00);
        end else begin
            mmis = 1'b0;
            full = (q.size() >= QDEPTH);
            popd = exp_v && id_ready;
            if (popd) void'(q.pop_front());
            if (!full || popd) begin
                q.push_back('{pc: mpc, ins: (mpc >> 2) ^ key});
                mpc = mpc + 32'd4;
            end
        end
    end

    initial begin
        logic [31:0] wrap_exp [3];
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; key = '0;

        // Reset values and free-running fetch from reset
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_pc_address", pc_address, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
        chk("rst_if_instruction", if_instruction, 32'h0000_0013);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_wrap_if_pc", ifp2, 32'hFFFF_FFF8);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("first_cycle_if_valid", {31'b0, if_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("stream_if_valid", {31'b0, if_valid}, 32'h1);
            chk("stream_if_pc", if_pc, 32'(4 * k));
            chk("stream_if_instruction", if_instruction, 32'(k));
            if (k < 3) chk("wrap_if_pc", ifp2, wrap_exp[k]);
        end

        // Stall with decode not ready, then drain
        @(posedge clk); #1 rst_n = 1'b0; id_ready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("stall_pc_address", pc_address, 32'h8);
        chk("stall_if_pc", if_pc, 32'h0);
        chk("stall_if_valid", {31'b0, if_valid}, 32'h1);
        @(posedge clk); #1 id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("drain_if_pc", if_pc, 32'(4 * k));
            if (k < 2) @(posedge clk);
        end

        // Redirect while full
        @(posedge clk); #1 id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
        @(negedge clk); #1;
        chk("redir_if_valid", {31'b0, if_valid}, 32'h0);
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk); #1;
        chk("redir_pc_address", pc_address, 32'h100);
        chk("redir_empty", {31'b0, if_valid}, 32'h0);
        @(negedge clk); #1;
        chk("redir_target_valid", {31'b0, if_valid}, 32'h1);
        chk("redir_target_pc", if_pc, 32'h100);

        // Misaligned redirect target
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h203;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk); #1;
        chk("mis_pc_address", pc_address, 32'h200);
        chk("mis_pulse", {31'b0, misaligned}, 32'h1);
        @(negedge clk); #1;
        chk("mis_clear", {31'b0, misaligned}, 32'h0);

        // Asynchronous reset between edges with a full queue
        @(posedge clk); #1 id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("pre_pulse_if_valid", {31'b0, if_valid}, 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("pulse_if_valid", {31'b0, if_valid}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("pulse_pc_address", pc_address, RPC);
        @(negedge clk); #1;
        chk("restart_if_valid", {31'b0, if_valid}, 32'h1);
        chk("restart_if_pc", if_pc, RPC);

        // Randomized traffic with back-to-back redirects and changing memory contents
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            id_ready       = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 8) == 0;
            redirect_pc    = $urandom;
            key            = $urandom;
        end
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter: DEPTH, 2, fetch-queue entries; fixed power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: pc_address  output  32  fetch address driven to instruction memory.
REQ-006 Port: instruction  input  32  word returned combinationally by instruction memory for pc_address in the same cycle.
REQ-007 Port: redirect_valid  input  1  branch/jump resolution requests a PC change.
REQ-008 Port: redirect_pc  input  32  redirect target.
REQ-009 Port: if_valid  output  1  queue head holds a valid instruction for decode.
REQ-010 Port: if_instruction  output  32  instruction at queue head.
REQ-011 Port: if_pc  output  32  PC of the queue-head instruction.
REQ-012 Port: id_ready  input  1  decode accepts the head this cycle.
REQ-013 Port: misaligned  output  1  one-cycle pulse flagging a redirect target with bits [1:0] non-zero.

Function
REQ-014 pc_address SHALL equal the internal PC register; its bits [1:0] SHALL always be 00.
REQ-015 pop = if_valid && id_ready; push = !redirect_valid && (count < DEPTH || pop).
REQ-016 On push, the queue SHALL store {pc, instruction} at the tail, and pc SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 If the queue is full and there is no pop, pc and the queue SHALL hold; pc_address SHALL stay stable.
REQ-018 if_valid SHALL equal (count != 0) && !redirect_valid; if_instruction and if_pc SHALL come from the head entry.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; the head and tail pointers SHALL each advance and wrap modulo DEPTH.
REQ-020 On redirect_valid, regardless of count, id_ready or fullness, the queue SHALL flush (count = 0 next cycle), no push or pop SHALL occur, and pc SHALL load {redirect_pc[31:2], 2'b00}.
REQ-021 misaligned SHALL be high for exactly the cycle after a redirect whose redirect_pc[1:0] != 0; otherwise low.
REQ-022 Latency: an instruction pushed in cycle N SHALL be presented with if_valid=1 in cycle N+1 at the earliest.
REQ-023 For a redirect in cycle N, pc_address SHALL equal the target in N+1, with if_valid=1 and if_pc=target in N+2.
REQ-024 Back-to-back redirects: the last one asserted SHALL win; each SHALL flush.
REQ-025 With id_ready held high and no redirects, the block SHALL sustain one instruction per cycle.
REQ-026 The instruction SHALL be captured only in the push cycle; instruction changes while stalled SHALL NOT alter queued entries.

Reset
REQ-027 While rst_n=0: pc=RESET_PC, queue empty, pointers 0, if_valid=0, misaligned=0, if_instruction=32'h0000_0013, if_pc=RESET_PC.
REQ-028 Reset assertion mid-operation SHALL take effect immediately without waiting for clk, discarding queued entries and any pending redirect.
REQ-029 In the first cycle after rst_n rises, the block SHALL push the word at RESET_PC.

Verification
REQ-030 Reset release, id_ready=1, memory word i = i -> if_pc 0,4,8,... on consecutive cycles starting one cycle after release; if_instruction 0,1,2,...
REQ-031 id_ready=0 for 5 cycles after reset -> count reaches 2, pc_address stalls at 0x8; if_pc stays 0x0; on id_ready=1 the bench sees 0x0, 0x4, 0x8 with no gap or duplicate.
REQ-032 Queue full, then redirect_valid=1 with redirect_pc=0x100 and id_ready=1 -> if_valid=0 that cycle; pc_address=0x100 next cycle; the cycle after, if_pc=0x100 and the old entries are never delivered.
REQ-033 redirect_pc=0x203 -> pc_address=0x200 and misaligned=1 for one cycle, then 0.
REQ-034 RESET_PC=32'hFFFF_FFF8 with free-running fetch -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 rst_n pulsed low between clock edges while the queue holds 2 entries -> if_valid drops to 0 at once; after release, fetching restarts at RESET_PC.
